qupls4_stomp_gen: RTL and testbench

- Generates the per-ROB-entry stomp vector after a branch mispredict: every valid entry younger than the mispredicted branch is marked for squash.
- Directly upstream of the stomped-instruction counter and the ROB stomp/valid update logic, which consume its stomp vector.
- Also supplies the recovered ROB tail index and a busy flag that holds off dispatch while recovery settles.

---
 rtl/qupls4_stomp_gen_if.sv | 31 +++
 rtl/qupls4_stomp_gen.sv | 142 ++++++++++++++
 tb/tb_qupls4_stomp_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/qupls4_stomp_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qupls4_stomp_gen_if : mispredict report in, stomp vector / tail recovery out
// Rev 1.0
// ----------------------------------------------------------------------------
interface qupls4_stomp_gen_if #(
  parameter int ROB_ENTRIES = 16,
  parameter int NDX_W       = 4
);
  logic                   ce;
  logic [NDX_W-1:0]       head;
  logic [ROB_ENTRIES-1:0] rob_v;
  logic                   mispredict_valid;
  logic [NDX_W-1:0]       mispredict_ndx;
  logic [ROB_ENTRIES-1:0] stomp;
  logic [NDX_W:0]         stomp_cnt;
  logic [NDX_W-1:0]       new_tail;
  logic                   new_tail_valid;
  logic                   busy;

  modport master (
    output ce, head, rob_v, mispredict_valid, mispredict_ndx,
    input  stomp, stomp_cnt, new_tail, new_tail_valid, busy
  );

  modport slave (
    input  ce, head, rob_v, mispredict_valid, mispredict_ndx,
    output stomp, stomp_cnt, new_tail, new_tail_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/qupls4_stomp_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qupls4_stomp_gen : squash vector and recovered tail after a branch mispredict
// Rev 1.0
// ----------------------------------------------------------------------------
module qupls4_stomp_gen #(
  parameter int ROB_ENTRIES = 16,
  parameter int NDX_W       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  qupls4_stomp_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STOMP = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [2:0] c_hold = 3'(HOLD_CYCLES);

  state_t                 state_q, state_d;
  logic [NDX_W-1:0]       b_q, b_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [ROB_ENTRIES-1:0] stomp_q, stomp_d;
  logic [NDX_W:0]         stomp_cnt_q, stomp_cnt_d;
  logic [NDX_W-1:0]       new_tail_q, new_tail_d;
  logic                   ntv_q, ntv_d;
  logic                   busy_q, busy_d;

  logic [ROB_ENTRIES-1:0] w_stomp_vec;
  logic [NDX_W:0]         w_pop;
  logic [NDX_W-1:0]       w_age_b;
  logic [NDX_W-1:0]       w_age_new;
  logic                   w_accept;
  logic                   w_older;

  // Ages wrap naturally in NDX_W bits, so no tail pointer is needed.
  assign w_age_b   = b_q - bus.head;
  assign w_age_new = bus.mispredict_ndx - bus.head;
  assign w_accept  = bus.ce & bus.mispredict_valid & bus.rob_v[bus.mispredict_ndx];
  assign w_older   = (w_age_new < w_age_b);

  generate
    for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_ent
      logic [NDX_W-1:0] w_age;
      assign w_age          = NDX_W'(i) - bus.head;
      assign w_stomp_vec[i] = bus.rob_v[i] & (w_age > w_age_b);
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < ROB_ENTRIES; i++) begin
      w_pop = w_pop + (NDX_W+1)'(w_stomp_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      cnt_q       <= '0;
      stomp_q     <= '0;
      stomp_cnt_q <= '0;
      new_tail_q  <= '0;
      ntv_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      stomp_q     <= stomp_d;
      stomp_cnt_q <= stomp_cnt_d;
      new_tail_q  <= new_tail_d;
      ntv_q       <= ntv_d;
      busy_q      <= busy_d;
    end
  end

  // Pulse outputs default low, so a ce-low cycle emits nothing and holds state.
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    stomp_d     = '0;
    stomp_cnt_d = '0;
    new_tail_d  = new_tail_q;
    ntv_d       = 1'b0;
    busy_d      = busy_q;
    if (bus.ce) begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_d = ST_STOMP;
            b_d     = bus.mispredict_ndx;
            busy_d  = 1'b1;
          end
        end
        ST_STOMP: begin
          stomp_d     = w_stomp_vec;
          stomp_cnt_d = w_pop;
          new_tail_d  = b_q + 1'b1;
          ntv_d       = 1'b1;
          cnt_d       = c_hold;
          state_d     = ST_HOLD;
          if (w_accept && w_older) begin
            state_d = ST_STOMP;
            b_d     = bus.mispredict_ndx;
          end
        end
        ST_HOLD: begin
          if (w_accept && w_older) begin
            state_d = ST_STOMP;
            b_d     = bus.mispredict_ndx;
            cnt_d   = c_hold;
          end else if (cnt_q == 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.stomp          = stomp_q;
  assign bus.stomp_cnt      = stomp_cnt_q;
  assign bus.new_tail       = new_tail_q;
  assign bus.new_tail_valid = ntv_q;
  assign bus.busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_qupls4_stomp_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qupls4_stomp_gen : vector table, directed corner sequences, random vs model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_qupls4_stomp_gen;
  localparam int N    = 16;
  localparam int W    = 4;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  qupls4_stomp_gen_if #(.ROB_ENTRIES(N), .NDX_W(W)) bus ();

  qupls4_stomp_gen #(.ROB_ENTRIES(N), .NDX_W(W), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] head;
    logic [N-1:0] rob_v;
    logic [W-1:0] ndx;
    logic [N-1:0] stomp;
    logic [W:0]   cnt;
    logic [W-1:0] tail;
  } vec_t;

  vec_t vecs [7];

  // Reference model: recovery tracked as "owed stomp" plus remaining hold cycles.
  bit           m_busy    = 1'b0;
  bit           m_pending = 1'b0;
  int           m_b       = 0;
  int           m_hold    = 0;
  int           m_tail    = 0;
  logic [N-1:0] e_stomp   = '0;
  int           e_cnt     = 0;
  bit           e_ntv     = 1'b0;

  function automatic int age(int i, int h);
    return (i - h + N) % N;
  endfunction

  task automatic compare(string name, logic [N-1:0] s, logic [W:0] c,
                         logic [W-1:0] t, logic v, logic b);
    n_tests++;
    if ({bus.stomp, bus.stomp_cnt, bus.new_tail, bus.new_tail_valid, bus.busy} !==
        {s, c, t, v, b}) begin
      n_fail++;
      $display("FAIL %s @%0t: got stomp=%h cnt=%0d tail=%0d ntv=%b busy=%b, expected stomp=%h cnt=%0d tail=%0d ntv=%b busy=%b",
               name, $time, bus.stomp, bus.stomp_cnt, bus.new_tail, bus.new_tail_valid,
               bus.busy, s, c, t, v, b);
    end
  endtask

  task automatic model_step(bit r, bit c, bit mv, int ndx, logic [N-1:0] rv, int h);
    int  old_b;
    bit  acc;
    e_stomp = '0;
    e_cnt   = 0;
    e_ntv   = 1'b0;
    if (r) begin
      m_busy = 0; m_pending = 0; m_b = 0; m_hold = 0; m_tail = 0;
    end else if (c) begin
      acc = mv && rv[ndx];
      if (!m_busy) begin
        if (acc) begin
          m_busy = 1; m_pending = 1; m_b = ndx;
        end
      end else begin
        old_b = m_b;
        if (m_pending) begin
          for (int i = 0; i < N; i++) begin
            if (rv[i] && age(i, h) > age(old_b, h)) begin
              e_stomp[i] = 1'b1;
              e_cnt++;
            end
          end
          m_tail    = (old_b + 1) % N;
          e_ntv     = 1'b1;
          m_pending = 0;
          m_hold    = HOLD;
        end else begin
          m_hold--;
          if (m_hold == 0) m_busy = 0;
        end
        if (acc && age(ndx, h) < age(old_b, h)) begin
          m_b = ndx; m_pending = 1; m_busy = 1;
        end
      end
    end
  endtask

  initial begin : ref_model
    forever begin
      @(posedge clk);
      model_step(rst, bus.ce, bus.mispredict_valid, int'(bus.mispredict_ndx),
                 bus.rob_v, int'(bus.head));
      #1;
      compare("model", e_stomp, (W+1)'(e_cnt), W'(m_tail), e_ntv, m_busy);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic report(logic [W-1:0] h, logic [N-1:0] rv, logic [W-1:0] n);
    bus.head             = h;
    bus.rob_v            = rv;
    bus.mispredict_ndx   = n;
    bus.mispredict_valid = 1'b1;
    cyc();
    bus.mispredict_valid = 1'b0;
  endtask

  initial begin : stim
    logic [W-1:0] last_tail;
    bus.ce               = 1'b1;
    bus.head             = '0;
    bus.rob_v            = '0;
    bus.mispredict_valid = 1'b0;
    bus.mispredict_ndx   = '0;
    vecs[0] = '{4'd2,  16'h03FC, 4'd5,  16'h03C0, 5'd4,  4'd6};
    vecs[1] = '{4'd12, 16'hF00F, 4'd14, 16'h800F, 5'd5,  4'd15};
    vecs[2] = '{4'd2,  16'h03FC, 4'd9,  16'h0000, 5'd0,  4'd10};
    vecs[3] = '{4'd0,  16'hFFFF, 4'd15, 16'h0000, 5'd0,  4'd0};
    vecs[4] = '{4'd0,  16'hFFFF, 4'd0,  16'hFFFE, 5'd15, 4'd1};
    vecs[5] = '{4'd8,  16'hFFFF, 4'd7,  16'h0000, 5'd0,  4'd8};
    vecs[6] = '{4'd10, 16'h3C05, 4'd12, 16'h2005, 5'd3,  4'd13};

    cyc();
    compare("reset", '0, '0, '0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    last_tail = '0;

    for (int k = 0; k < 7; k++) begin
      report(vecs[k].head, vecs[k].rob_v, vecs[k].ndx);
      compare("vec_accept", '0, '0, last_tail, 1'b0, 1'b1);
      cyc();
      compare("vec_stomp", vecs[k].stomp, vecs[k].cnt, vecs[k].tail, 1'b1, 1'b1);
      last_tail = vecs[k].tail;
      cyc();
      compare("vec_hold", '0, '0, last_tail, 1'b0, 1'b1);
      cyc();
      compare("vec_idle", '0, '0, last_tail, 1'b0, 1'b0);
    end

    // Overlap: older report during HOLD re-stomps, younger one is ignored
    report(4'd2, 16'h0FFC, 4'd7);
    compare("ovl_accept", '0, '0, 4'd13, 1'b0, 1'b1);
    cyc();
    compare("ovl_stomp1", 16'h0F00, 5'd4, 4'd8, 1'b1, 1'b1);
    report(4'd2, 16'h0FFC, 4'd4);
    compare("ovl_reaccept", '0, '0, 4'd8, 1'b0, 1'b1);
    cyc();
    compare("ovl_stomp2", 16'h0FE0, 5'd7, 4'd5, 1'b1, 1'b1);
    report(4'd2, 16'h0FFC, 4'd9);
    compare("ovl_younger", '0, '0, 4'd5, 1'b0, 1'b1);
    cyc();
    compare("ovl_done", '0, '0, 4'd5, 1'b0, 1'b0);

    report(4'd2, 16'h03FC, 4'd12);
    compare("invalid_ign", '0, '0, 4'd5, 1'b0, 1'b0);
    cyc();
    compare("invalid_idle", '0, '0, 4'd5, 1'b0, 1'b0);

    // ce gating on the emitting cycle and inside HOLD
    report(4'd2, 16'h03FC, 4'd5);
    bus.ce = 1'b0;
    compare("ce_accept", '0, '0, 4'd5, 1'b0, 1'b1);
    cyc();
    bus.ce = 1'b1;
    compare("ce_frozen", '0, '0, 4'd5, 1'b0, 1'b1);
    cyc();
    compare("ce_stomp", 16'h03C0, 5'd4, 4'd6, 1'b1, 1'b1);
    cyc();
    bus.ce = 1'b0;
    compare("ce_hold", '0, '0, 4'd6, 1'b0, 1'b1);
    cyc();
    bus.ce = 1'b1;
    compare("ce_hold_frz", '0, '0, 4'd6, 1'b0, 1'b1);
    cyc();
    compare("ce_idle", '0, '0, 4'd6, 1'b0, 1'b0);

    // Reset during HOLD, then a fresh recovery
    report(4'd2, 16'h03FC, 4'd5);
    cyc();
    compare("rst_pre", 16'h03C0, 5'd4, 4'd6, 1'b1, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    compare("rst_mid", '0, '0, '0, 1'b0, 1'b0);
    report(4'd2, 16'h03FC, 4'd5);
    compare("rst_accept", '0, '0, '0, 1'b0, 1'b1);
    cyc();
    compare("rst_stomp", 16'h03C0, 5'd4, 4'd6, 1'b1, 1'b1);
    cyc();
    cyc();
    compare("rst_idle", '0, '0, 4'd6, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      rst                  = ($urandom_range(0, 63) == 0);
      bus.ce               = ($urandom_range(0, 7) != 0);
      bus.mispredict_valid = ($urandom_range(0, 9) < 4);
      bus.mispredict_ndx   = W'($urandom_range(0, N-1));
      bus.head             = W'($urandom_range(0, N-1));
      bus.rob_v            = N'($urandom);
      cyc();
    end
    rst                  = 1'b0;
    bus.mispredict_valid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
